// File: rtl/matrix_alu_pkg.sv
// Shared opcodes, FSM state encoding and sizing helpers for the sequential matrix ALU.
package matrix_alu_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_OPP    = 3'd4;
    localparam logic [2:0] OP_TRANSP = 3'd5;
    localparam logic [2:0] OP_SCALAR = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

    // Product is 2W bits; 3 guard bits cover the sum of up to 8 products.
    function automatic int acc_width(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/matrix_elem_unit.sv
// Combinational per-element operation shared by all element-wise opcodes.
module matrix_elem_unit
    import matrix_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] scalar_i,
    input  logic [2:0]   op_i,
    output logic [W-1:0] res_o,
    output logic         ovf_o
);
    localparam int EW = 2 * W;

    logic signed [EW-1:0] ax, bx, sx, exact;

    always_comb begin
        ax    = {{W{a_i[W-1]}}, a_i};
        bx    = {{W{b_i[W-1]}}, b_i};
        sx    = {{W{scalar_i[W-1]}}, scalar_i};
        exact = '0;
        case (op_i)
            OP_ADD:    exact = ax + bx;
            OP_SUB:    exact = ax - bx;
            OP_OPP:    exact = -ax;
            OP_TRANSP: exact = ax;
            OP_SCALAR: exact = sx * ax;
            default:   exact = '0;
        endcase
        res_o = exact[W-1:0];
        // In range only if the bits from the W-bit sign position upward all agree.
        ovf_o = !((&exact[EW-1:W-1]) || !(|exact[EW-1:W-1]));
    end

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential N x N matrix ALU: one element (or one MAC for multiply) per cycle,
// framed by a start/busy/done handshake with sticky overflow and request error.
module matrix_alu_seq
    import matrix_alu_pkg::*;
#(
    parameter int MAX_N = 5,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               opcode,
    input  logic [2:0]               matrix_size,
    input  logic [W-1:0]             scalar,
    input  logic [MAX_N*MAX_N*W-1:0] A_flat,
    input  logic [MAX_N*MAX_N*W-1:0] B_flat,
    output logic [MAX_N*MAX_N*W-1:0] C_flat,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow_flag,
    output logic                     error
);
    localparam int FW = MAX_N * MAX_N * W;
    localparam int AW = acc_width(W);

    state_e               state_q;
    logic [2:0]           op_q, n_q, row_q, col_q, k_q;
    logic [W-1:0]         scal_q;
    logic [FW-1:0]        a_q, b_q, res_q;
    logic signed [AW-1:0] acc_q, acc_d, prod;
    logic                 busy_q, done_q, ovf_q, err_q;

    int           idx_rc, idx_cr, idx_rk, idx_kc;
    logic [W-1:0] ea, eb, ma, mb, eres;
    logic         eovf, aovf, last_k, last_c, last_r, legal;

    always_comb begin
        idx_rc = int'(row_q) * MAX_N + int'(col_q);
        idx_cr = int'(col_q) * MAX_N + int'(row_q);
        idx_rk = int'(row_q) * MAX_N + int'(k_q);
        idx_kc = int'(k_q) * MAX_N + int'(col_q);
        ea     = (op_q == OP_TRANSP) ? a_q[idx_cr*W +: W] : a_q[idx_rc*W +: W];
        eb     = b_q[idx_rc*W +: W];
        ma     = a_q[idx_rk*W +: W];
        mb     = b_q[idx_kc*W +: W];
        prod   = {{(AW-W){ma[W-1]}}, ma} * {{(AW-W){mb[W-1]}}, mb};
        acc_d  = (k_q == 3'd0) ? prod : acc_q + prod;
        aovf   = !((&acc_d[AW-1:W-1]) || !(|acc_d[AW-1:W-1]));
        last_k = (k_q == n_q - 3'd1);
        last_c = (col_q == n_q - 3'd1);
        last_r = (row_q == n_q - 3'd1);
        legal  = (n_q != 3'd0) && (int'(n_q) <= MAX_N) &&
                 (op_q != OP_NOP) && (op_q != OP_RSVD);
    end

    matrix_elem_unit #(.W(W)) u_elem (
        .a_i      (ea),
        .b_i      (eb),
        .scalar_i (scal_q),
        .op_i     (op_q),
        .res_o    (eres),
        .ovf_o    (eovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            n_q     <= '0;
            scal_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q    <= opcode;
                    n_q     <= matrix_size;
                    scal_q  <= scalar;
                    a_q     <= A_flat;
                    b_q     <= B_flat;
                    busy_q  <= 1'b1;
                    state_q <= CLEAR;
                end
                CLEAR: begin
                    res_q <= '0;
                    ovf_q <= 1'b0;
                    err_q <= 1'b0;
                    row_q <= '0;
                    col_q <= '0;
                    k_q   <= '0;
                    acc_q <= '0;
                    if (legal) begin
                        state_q <= RUN;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                RUN: begin
                    if (op_q == OP_MUL) begin
                        acc_q <= acc_d;
                        k_q   <= last_k ? 3'd0 : k_q + 3'd1;
                    end
                    // An element completes every cycle, or on the last k for multiply.
                    if (op_q != OP_MUL || last_k) begin
                        res_q[idx_rc*W +: W] <= (op_q == OP_MUL) ? acc_d[W-1:0] : eres;
                        if ((op_q == OP_MUL) ? aovf : eovf) ovf_q <= 1'b1;
                        if (last_c) begin
                            col_q <= '0;
                            row_q <= row_q + 3'd1;
                        end else begin
                            col_q <= col_q + 3'd1;
                        end
                        if (last_c && last_r) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign C_flat        = res_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow_flag = ovf_q;
    assign error         = err_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed and randomized bench for matrix_alu_seq against a plain-arithmetic matrix model.
module tb_matrix_alu_seq;
    localparam int MAX_N = 5;
    localparam int W     = 8;
    localparam int FW    = MAX_N * MAX_N * W;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [2:0]    opcode, matrix_size;
    logic [W-1:0]  scalar;
    logic [FW-1:0] A_flat, B_flat, C_flat;
    logic          busy, done, overflow_flag, error;

    int checks = 0;
    int errors = 0;

    int            A [MAX_N][MAX_N];
    int            B [MAX_N][MAX_N];
    logic [FW-1:0] exp_c;
    logic          exp_ovf, exp_err;
    int            exp_lat;

    matrix_alu_seq #(.MAX_N(MAX_N), .W(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .matrix_size   (matrix_size),
        .scalar        (scalar),
        .A_flat        (A_flat),
        .B_flat        (B_flat),
        .C_flat        (C_flat),
        .busy          (busy),
        .done          (done),
        .overflow_flag (overflow_flag),
        .error         (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_ab();
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                A[r][c] = 0;
                B[r][c] = 0;
            end
    endtask

    // Reference: exact integer results, truncated to W bits, with range check.
    task automatic model(input int op, input int n, input int s);
        int v;
        exp_c   = '0;
        exp_ovf = 1'b0;
        exp_err = !(n >= 1 && n <= MAX_N && op >= 1 && op <= 6);
        if (exp_err) begin
            exp_lat = 1;
            return;
        end
        exp_lat = ((op == 3) ? n * n * n : n * n) + 1;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                case (op)
                    1: v = A[r][c] + B[r][c];
                    2: v = A[r][c] - B[r][c];
                    3: begin
                        v = 0;
                        for (int k = 0; k < n; k++) v += A[r][k] * B[k][c];
                    end
                    4: v = -A[r][c];
                    5: v = A[c][r];
                    default: v = s * A[r][c];
                endcase
                if (v > 127 || v < -128) exp_ovf = 1'b1;
                exp_c[(r*MAX_N+c)*W +: W] = W'(v);
            end
    endtask

    task automatic run_op(input int op, input int n, input int s, input string tag, input bit repulse);
        int lat;
        bit busy_ok;
        model(op, n, s);
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                A_flat[(r*MAX_N+c)*W +: W] = W'(A[r][c]);
                B_flat[(r*MAX_N+c)*W +: W] = W'(B[r][c]);
            end
        opcode      = op[2:0];
        matrix_size = n[2:0];
        scalar      = s[W-1:0];
        start       = 1'b1;
        @(posedge clock); #1;
        start   = 1'b0;
        A_flat  = ~A_flat;
        B_flat  = ~B_flat;
        busy_ok = busy;
        lat     = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (repulse && cyc == 3) begin
                start       = 1'b1;
                opcode      = 3'd2;
                matrix_size = 3'd1;
            end
            @(posedge clock); #1;
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = cyc;
                break;
            end
            if (!busy) break;
        end
        check({tag, "_latency"}, FW'(lat), FW'(exp_lat));
        check({tag, "_busy"}, FW'(busy_ok), FW'(1));
        check({tag, "_C"}, C_flat, exp_c);
        check({tag, "_ovf"}, FW'(overflow_flag), FW'(exp_ovf));
        check({tag, "_err"}, FW'(error), FW'(exp_err));
        @(posedge clock); #1;
        check({tag, "_idle"}, FW'({busy, done}), FW'(0));
        if (repulse) begin
            repeat (4) @(posedge clock);
            #1;
            check({tag, "_no2nd"}, FW'({busy, done}), FW'(0));
            check({tag, "_hold"}, C_flat, exp_c);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; matrix_size = '0;
        scalar = '0; A_flat = '0; B_flat = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_C", C_flat, '0);
        check("reset_flags", FW'({busy, done, overflow_flag, error}), FW'(0));
        reset = 1'b0;

        clear_ab();
        A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
        B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
        run_op(1, 2, 0, "add2", 1'b0);
        check("add2_c11", FW'(C_flat[(MAX_N+1)*W +: W]), FW'(12));
        run_op(3, 2, 0, "mul2", 1'b0);
        check("mul2_c10", FW'(C_flat[MAX_N*W +: W]), FW'(43));

        clear_ab();
        A[0][0] = 100; A[0][1] = 100; B[0][0] = 1; B[1][0] = 1;
        run_op(3, 2, 0, "mulwrap", 1'b0);
        check("mulwrap_c00", FW'(C_flat[W-1:0]), FW'(8'hC8));
        check("mulwrap_ovf", FW'(overflow_flag), FW'(1));

        clear_ab();
        for (int i = 0; i < 9; i++) A[i/3][i%3] = i + 1;
        run_op(5, 3, 0, "transp3", 1'b0);
        check("transp3_c01", FW'(C_flat[W +: W]), FW'(4));
        A[0][0] = -128;
        run_op(4, 3, 0, "opp3", 1'b0);
        check("opp3_c00", FW'(C_flat[W-1:0]), FW'(8'h80));

        clear_ab();
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) A[r][c] = r + c;
        A[0][0] = -3; A[4][4] = 64;
        run_op(6, 5, 2, "scal5", 1'b1);
        check("scal5_c44", FW'(C_flat[(4*MAX_N+4)*W +: W]), FW'(8'h80));
        check("scal5_c00", FW'(C_flat[W-1:0]), FW'(8'hFA));

        run_op(1, 6, 0, "ill_n6", 1'b0);
        run_op(1, 3, 0, "refill", 1'b0);
        run_op(1, 0, 0, "ill_n0", 1'b0);
        run_op(7, 2, 0, "ill_op7", 1'b0);
        run_op(0, 2, 0, "ill_nop", 1'b0);

        // Reset in the middle of a multiply, after some elements are written.
        clear_ab();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                A[r][c] = 50;
                B[r][c] = 3;
            end
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++) begin
                A_flat[(r*MAX_N+c)*W +: W] = W'(A[r][c]);
                B_flat[(r*MAX_N+c)*W +: W] = W'(B[r][c]);
            end
        opcode = 3'd3; matrix_size = 3'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("midrun_partial", FW'(C_flat != '0), FW'(1));
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrun_rst_C", C_flat, '0);
        check("midrun_rst_flags", FW'({busy, done, overflow_flag, error}), FW'(0));
        start = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        check("start_with_reset", FW'(busy), FW'(0));
        clear_ab();
        A[1][1] = 20; B[1][1] = -7; A[0][1] = 127; B[0][1] = 1;
        run_op(1, 2, 0, "post_rst_add", 1'b0);

        for (int it = 0; it < 16; it++) begin
            int op, n, s;
            op = int'($urandom_range(1, 6));
            n  = int'($urandom_range(1, MAX_N));
            s  = int'($urandom_range(0, 255)) - 128;
            for (int r = 0; r < MAX_N; r++)
                for (int c = 0; c < MAX_N; c++) begin
                    A[r][c] = int'($urandom_range(0, 255)) - 128;
                    B[r][c] = (it < 8) ? int'($urandom_range(0, 15)) - 8
                                       : int'($urandom_range(0, 255)) - 128;
                end
            run_op(op, n, s, $sformatf("rand%0d_op%0d_n%0d", it, op, n), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_alu_seq.md
Name: matrix_alu_seq

Overview:
Parametrised, sequential successor to the combinational matrix ALU. It operates on an N×N signed matrix, with N selectable at runtime up to MAX_N, and processes one element per cycle: element-wise ops take N*N cycles and multiply takes N*N*N cycles, one MAC per cycle. A start/busy/done handshake frames each operation, and a sticky overflow flag is reported. It sits between the host register interface and the matrix storage, in place of the single-cycle ALU.

Parameters:
MAX_N, 5, maximum matrix dimension; flat buses hold MAX_N*MAX_N elements.
W, 8, element width in bits, two's complement.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle request; sampled only in IDLE.
opcode  in  3  operation select; encodings are in the package.
matrix_size  in  3  runtime N; valid range 1..MAX_N.
scalar  in  W  signed multiplier for OP_SCALAR.
A_flat  in  MAX_N*MAX_N*W  operand A; element (r,c) at [(r*MAX_N+c)*W +: W].
B_flat  in  MAX_N*MAX_N*W  operand B; same layout.
C_flat  out  MAX_N*MAX_N*W  result; same layout; registered.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when C_flat is final.
overflow_flag  out  1  sticky per operation.
error  out  1  operation rejected; valid with done.

Behaviour:
- Reset: synchronous and active-high on clock. All outputs go to 0 (C_flat all zero). State returns to IDLE. Reset wins over any other event, including mid-operation; a partial result is discarded.
- States:
  - IDLE: on start=1, latch opcode, matrix_size, scalar, A_flat and B_flat, then go to CLEAR.
  - CLEAR: one cycle. Zero C_flat, overflow_flag and error. Go to RUN, or to DONE with error=1 if the request is illegal.
  - RUN: L cycles.
  - DONE: one cycle with done=1, then IDLE.
- busy is 1 in CLEAR, RUN and DONE.
- Latency: with start sampled at edge 0, done is high after edge L+1.
  - Element-wise ops: L = N*N.
  - OP_MUL: L = N*N*N.
  - Illegal request: L = 0, so done follows CLEAR directly.
- Illegal requests: matrix_size = 0, matrix_size > MAX_N, OP_NOP, or the reserved opcode 7. The result is C_flat = 0 and error = 1.
- RUN order is row-major: r is outer, then c; for multiply, k is innermost.
  - Element-wise ops write C(r,c) on the edge ending that cycle.
  - Multiply accumulates A(r,k)*B(k,c) into a 2W+3-bit signed accumulator, which cannot overflow for MAX_N ≤ 8. The accumulator is cleared at k=0 and C(r,c) is written at k=N-1.
- Operations:
  - ADD: A+B.
  - SUB: A−B.
  - OPP: −A.
  - TRANSP: C(r,c) = A(c,r).
  - SCALAR: scalar*A.
  - MUL: A×B.
- Result width: every result is truncated to W bits (wraps). overflow_flag is set if any written element's exact value lies outside [−2^(W−1), 2^(W−1)−1]. For MUL the check uses the final accumulator value only. TRANSP never overflows. OPP of −2^(W−1) does overflow.
- Elements with r ≥ N or c ≥ N stay 0.
- C_flat, overflow_flag and error hold their values after done until the next accepted start or reset.
- start is ignored while busy=1; no queuing.
- Operand inputs may change after acceptance without affecting the result.
- start coincident with reset is dropped.

Decomposition:
- Package matrix_alu_pkg holds:
  - opcode constants: OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_OPP=4, OP_TRANSP=5, OP_SCALAR=6; 7 is reserved.
  - state encoding: IDLE, CLEAR, RUN, DONE.
  - accumulator width function.
- One sub-module, matrix_elem_unit: a combinational per-element operation. Inputs are two W-bit operands, the scalar and the opcode. Outputs are the W-bit result and an out-of-range bit. It is shared by all element-wise ops. The top level holds the FSM, the r/c/k counters, the accumulator and the C register.

Test Plan:
1. N=2, ADD, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[6,8],[10,12]], overflow=0, done after edge 5, busy high on edges 1..5.
2. N=2, MUL with the same A and B -> C=[[19,22],[43,50]], done after edge 9. Repeat with A=[[100,100],[0,0]], B=[[1,0],[1,0]] -> C(0,0)=−56 (200 wrapped), overflow=1.
3. N=3: TRANSP of A=1..9 row-major -> C=[[1,4,7],[2,5,8],[3,6,9]] and all other elements 0. OPP with A(0,0)=−128 -> C(0,0)=−128, overflow=1.
4. N=5, SCALAR with scalar=2, A(0,0)=−3 and A(4,4)=64 -> C(0,0)=−6, C(4,4)=−128 (wrapped), overflow=1. Pulse start again during RUN -> ignored, single done.
5. matrix_size=6 or 0, or opcode=7 -> done after edge 1, error=1, C_flat all zero.
6. Assert reset during RUN of a MUL -> next cycle: all outputs 0, busy=0. A fresh ADD then completes correctly.
